pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Sequencing controller for the 5-stage MIPS pipeline. It consumes the hazard unit's RAW indication, the EX-stage branch resolution, the multi-cycle mul/div handshake and the memory wait line. It drives the PC and pipeline-register write enables and flush controls. It also keeps saturating stall and flush performance counters.

Parameters:
RAW_STALL_CYCLES, 2, bubble cycles inserted per RAW hazard (no forwarding path); legal 1..15
MD_TIMEOUT, 64, cycles in MD_WAIT without MulDivDone before abort
CNT_WIDTH, 16, width of performance counters

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-low
RawHazard  in  1  hazard unit: instruction in ID depends on an in-flight writer
BranchTaken  in  1  branch/jump resolved taken in EX this cycle
MulDivStart  in  1  ID stage holds a mul/div that enters EX this cycle
MulDivDone  in  1  mul/div unit result valid this cycle
MemWait  in  1  instruction or data memory not ready
PCWrite  out  1  PC load enable
IF_ID_Write  out  1  IF/ID register enable
ID_EX_Write  out  1  ID/EX register enable
IF_ID_Flush  out  1  clear IF/ID to nop
ID_EX_Flush  out  1  load nop control into ID/EX
EX_MEM_Flush  out  1  load nop control into EX/MEM
MdTimeout  out  1  sticky error flag
StallCount  out  CNT_WIDTH  cycles with PCWrite=0 caused by this block
FlushCount  out  CNT_WIDTH  taken-branch flush events

Behaviour:
- States: RUN, RAW_STALL, MD_WAIT. State is registered. Outputs are combinational from state and inputs, so a stall takes effect in the detect cycle.
- Reset low at a rising edge: state=RUN, stall counter=0, MD timer=0, MdTimeout=0, StallCount=0, FlushCount=0.
- While Reset is low, outputs are PCWrite=IF_ID_Write=ID_EX_Write=0 and all three flushes are 1.
- Default outputs (RUN, no event): all writes 1, all flushes 0.
- Priority each cycle: MemWait > BranchTaken > state action > MulDivStart > RawHazard.
- MemWait=1: all writes 0, all flushes 0. State, timers and counters hold. StallCount does not increment.
- BranchTaken=1 (any state):
  - IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, writes 1.
  - FlushCount+1.
  - Next state RUN. A pending RAW stall is aborted because the dependent instruction is squashed.
  - In MD_WAIT the mul/div in EX is older and cannot be squashed, so BranchTaken in MD_WAIT is a protocol error and is ignored.
- RUN + MulDivStart: normal advance this cycle; next state MD_WAIT with timer=0.
- RUN + RawHazard:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, StallCount+1.
  - If RAW_STALL_CYCLES>1: next state RAW_STALL, stall counter=RAW_STALL_CYCLES-1.
  - Otherwise stay in RUN.
- RAW_STALL:
  - Same stall outputs as RUN + RawHazard; StallCount+1; counter decrements.
  - When counter=1 this is the last stall cycle; next state RUN.
  - RawHazard is ignored while in this state.
- MD_WAIT, MulDivDone=0:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Flush=1; StallCount+1; timer+1.
  - When timer reaches MD_TIMEOUT-1 with no Done: MdTimeout<=1, next state RUN.
- MD_WAIT, MulDivDone=1: default outputs, no stall; next state RUN.
  - A MulDivStart in the same cycle re-enters MD_WAIT (back-to-back mul/div).
  - RawHazard in this cycle is handled as in RUN.
- StallCount and FlushCount saturate at all-ones and never wrap.
- MdTimeout is cleared only by reset.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding constants (RUN=2'd0, RAW_STALL=2'd1, MD_WAIT=2'd2)
  - the nop control-word constant used by the flush logic
- One natural sub-module: sat_counter (parameterised width, enable, synchronous active-low clear). It is instantiated twice, for StallCount and FlushCount.

Test Plan:
- Reset low for 2 cycles, then high with no inputs -> during reset all writes 0 and flushes 1; after reset all writes 1, flushes 0, counters 0.
- RawHazard pulse 1 cycle, RAW_STALL_CYCLES=2 -> PCWrite=0 for exactly 2 cycles, ID_EX_Flush=1 both cycles, StallCount=2, then RUN.
- RawHazard and BranchTaken in the same cycle -> PCWrite=1, IF_ID_Flush=ID_EX_Flush=1, FlushCount=1, StallCount=0, state RUN.
- MulDivStart, then MulDivDone on the 4th MD_WAIT cycle -> 3 cycles with ID_EX_Write=0 and EX_MEM_Flush=1, StallCount=3, resume RUN.
- MulDivStart with MulDivDone never asserted, MD_TIMEOUT=64 -> MdTimeout=1 after 64 wait cycles, state RUN, StallCount=63.
- MemWait held 5 cycles in the middle of a RAW stall -> all outputs frozen with flushes 0, stall counter and StallCount unchanged, stall resumes afterward; preload StallCount to 0xFFFF -> it stays 0xFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller:
// state encoding and the control words it can drive.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        RAW_STALL = 2'd1,
        MD_WAIT   = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_wr;
        logic if_id_wr;
        logic id_ex_wr;
        logic if_id_fl;
        logic id_ex_fl;
        logic ex_mem_fl;
    } ctrl_t;

    // Nop word: nothing advances, every stage register cleared
    localparam ctrl_t CTRL_NOP    = 6'b000_111;
    localparam ctrl_t CTRL_RUN    = 6'b111_000;
    localparam ctrl_t CTRL_FREEZE = 6'b000_000;
    localparam ctrl_t CTRL_BRANCH = 6'b111_110;
    localparam ctrl_t CTRL_RAW    = 6'b001_010;
    localparam ctrl_t CTRL_MD     = 6'b000_001;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous
// active-low clear; used for the performance counters.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencing controller: RAW bubbles, mul/div wait,
// branch flush, memory freeze and saturating perf counters.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RAW_STALL_CYCLES = 2,
    parameter int MD_TIMEOUT       = 64,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 RawHazard,
    input  logic                 BranchTaken,
    input  logic                 MulDivStart,
    input  logic                 MulDivDone,
    input  logic                 MemWait,
    output logic                 PCWrite,
    output logic                 IF_ID_Write,
    output logic                 ID_EX_Write,
    output logic                 IF_ID_Flush,
    output logic                 ID_EX_Flush,
    output logic                 EX_MEM_Flush,
    output logic                 MdTimeout,
    output logic [CNT_WIDTH-1:0] StallCount,
    output logic [CNT_WIDTH-1:0] FlushCount
);

    localparam int TW = $clog2(MD_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(MD_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [3:0]    raw_cnt_q, raw_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q, timeout_d;
    ctrl_t         ctrl, ctrl_out;
    logic          stall_inc, flush_inc;

    always_comb begin
        state_d   = state_q;
        raw_cnt_d = raw_cnt_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        ctrl      = CTRL_RUN;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (MemWait) begin
            ctrl = CTRL_FREEZE;
        end else if (BranchTaken && (state_q != MD_WAIT)) begin
            ctrl      = CTRL_BRANCH;
            flush_inc = 1'b1;
            state_d   = RUN;
        end else if (state_q == RAW_STALL) begin
            ctrl      = CTRL_RAW;
            stall_inc = 1'b1;
            raw_cnt_d = raw_cnt_q - 4'd1;
            if (raw_cnt_q == 4'd1) begin
                state_d = RUN;
            end
        end else if ((state_q == MD_WAIT) && !MulDivDone
                     && (timer_q != TMAX)) begin
            ctrl      = CTRL_MD;
            stall_inc = 1'b1;
            timer_d   = timer_q + TW'(1);
        end else begin
            // RUN, or MD_WAIT releasing on Done or on timeout abort
            state_d = RUN;
            if ((state_q == MD_WAIT) && !MulDivDone) begin
                timeout_d = 1'b1;
            end
            if (MulDivStart) begin
                state_d = MD_WAIT;
                timer_d = '0;
            end else if (RawHazard) begin
                ctrl      = CTRL_RAW;
                stall_inc = 1'b1;
                if (RAW_STALL_CYCLES > 1) begin
                    state_d   = RAW_STALL;
                    raw_cnt_d = 4'(RAW_STALL_CYCLES - 1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= RUN;
            raw_cnt_q <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            raw_cnt_q <= raw_cnt_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .en_i   (stall_inc),
        .cnt_o  (StallCount)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .en_i   (flush_inc),
        .cnt_o  (FlushCount)
    );

    assign ctrl_out     = Reset ? ctrl : CTRL_NOP;
    assign PCWrite      = ctrl_out.pc_wr;
    assign IF_ID_Write  = ctrl_out.if_id_wr;
    assign ID_EX_Write  = ctrl_out.id_ex_wr;
    assign IF_ID_Flush  = ctrl_out.if_id_fl;
    assign ID_EX_Flush  = ctrl_out.id_ex_fl;
    assign EX_MEM_Flush = ctrl_out.ex_mem_fl;
    assign MdTimeout    = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus random
// traffic against a bubble-counting reference model.
module tb_pipeline_stall_ctrl;

    localparam int RAWC = 2;
    localparam int MDT  = 64;

    logic Clk = 1'b0;
    logic Reset, RawHazard, BranchTaken, MulDivStart, MulDivDone, MemWait;
    logic PCWrite, IF_ID_Write, ID_EX_Write;
    logic IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MdTimeout;
    logic [15:0] StallCount, FlushCount;
    logic s_pc, s_ifw, s_idw, s_iff, s_idf, s_exf, s_to;
    logic [3:0] s_sc, s_fc;

    int checks = 0;
    int failures = 0;

    // reference model: remaining bubbles, mul/div age, raw counts
    int m_raw_left, m_md_age, m_sc, m_fc;
    bit m_md_busy, m_to;
    logic [5:0] exp_o, obs_o;

    always #5 Clk = ~Clk;

    pipeline_stall_ctrl #(
        .RAW_STALL_CYCLES(RAWC), .MD_TIMEOUT(MDT), .CNT_WIDTH(16)
    ) dut (
        .Clk(Clk), .Reset(Reset), .RawHazard(RawHazard),
        .BranchTaken(BranchTaken), .MulDivStart(MulDivStart),
        .MulDivDone(MulDivDone), .MemWait(MemWait),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .ID_EX_Write(ID_EX_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
        .MdTimeout(MdTimeout), .StallCount(StallCount),
        .FlushCount(FlushCount)
    );

    pipeline_stall_ctrl #(
        .RAW_STALL_CYCLES(RAWC), .MD_TIMEOUT(MDT), .CNT_WIDTH(4)
    ) dut_small (
        .Clk(Clk), .Reset(Reset), .RawHazard(RawHazard),
        .BranchTaken(BranchTaken), .MulDivStart(MulDivStart),
        .MulDivDone(MulDivDone), .MemWait(MemWait),
        .PCWrite(s_pc), .IF_ID_Write(s_ifw), .ID_EX_Write(s_idw),
        .IF_ID_Flush(s_iff), .ID_EX_Flush(s_idf),
        .EX_MEM_Flush(s_exf), .MdTimeout(s_to),
        .StallCount(s_sc), .FlushCount(s_fc)
    );

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // one clock: drive, evaluate model + sample outputs mid-cycle
    task automatic step(input bit r, input bit raw, input bit br,
                        input bit st, input bit dn, input bit mw);
        Reset = r; RawHazard = raw; BranchTaken = br;
        MulDivStart = st; MulDivDone = dn; MemWait = mw;
        @(negedge Clk);
        exp_o = 6'b111000;
        if (!r) begin
            exp_o = 6'b000111;
            m_raw_left = 0; m_md_busy = 0; m_md_age = 0;
            m_to = 0; m_sc = 0; m_fc = 0;
        end else if (mw) begin
            exp_o = 6'b000000;
        end else if (br && !m_md_busy) begin
            exp_o = 6'b111110;
            m_fc++;
            m_raw_left = 0;
        end else if (m_raw_left > 0) begin
            exp_o = 6'b001010;
            m_sc++;
            m_raw_left--;
        end else if (m_md_busy && !dn && m_md_age < MDT - 1) begin
            exp_o = 6'b000001;
            m_sc++;
            m_md_age++;
        end else begin
            if (m_md_busy && !dn) m_to = 1;
            m_md_busy = 0;
            if (st) begin
                m_md_busy = 1;
                m_md_age = 0;
            end else if (raw) begin
                exp_o = 6'b001010;
                m_sc++;
                m_raw_left = RAWC - 1;
            end
        end
        obs_o = {PCWrite, IF_ID_Write, ID_EX_Write,
                 IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush};
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if (obs_o !== 6'b000111) begin
                failures++;
                $display("FAIL reset_out obs=%b exp=%b", obs_o, 6'b000111);
            end
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs_o !== 6'b111000) begin
            failures++;
            $display("FAIL idle_out obs=%b exp=%b", obs_o, 6'b111000);
        end
        checks++;
        if (StallCount !== 16'd0 || FlushCount !== 16'd0
            || MdTimeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt obs=%0d/%0d/%b exp=0/0/0",
                     StallCount, FlushCount, MdTimeout);
        end
    endtask

    task automatic test_raw();
        int base = m_sc;
        int pc0 = 0;
        step(1, 1, 0, 0, 0, 0);
        if (!obs_o[5]) pc0++;
        checks++;
        if (obs_o !== exp_o || obs_o !== 6'b001010) begin
            failures++;
            $display("FAIL raw_detect obs=%b exp=%b", obs_o, 6'b001010);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 0);
            if (!obs_o[5]) pc0++;
            checks++;
            if (obs_o !== exp_o) begin
                failures++;
                $display("FAIL raw_seq obs=%b exp=%b", obs_o, exp_o);
            end
        end
        checks++;
        if (pc0 != 2 || int'(StallCount) != base + 2) begin
            failures++;
            $display("FAIL raw_len obs=%0d,%0d exp=2,%0d",
                     pc0, StallCount, base + 2);
        end
    endtask

    task automatic test_raw_branch();
        int sc0 = m_sc;
        int fc0 = m_fc;
        step(1, 1, 1, 0, 0, 0);
        checks++;
        if (obs_o !== 6'b111110) begin
            failures++;
            $display("FAIL raw_br obs=%b exp=%b", obs_o, 6'b111110);
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs_o !== 6'b111000) begin
            failures++;
            $display("FAIL raw_br_after obs=%b exp=%b", obs_o, 6'b111000);
        end
        checks++;
        if (int'(FlushCount) != fc0 + 1 || int'(StallCount) != sc0) begin
            failures++;
            $display("FAIL raw_br_cnt obs=%0d,%0d exp=%0d,%0d",
                     FlushCount, StallCount, fc0 + 1, sc0);
        end
    endtask

    task automatic test_muldiv();
        int sc0 = m_sc;
        step(1, 0, 0, 1, 0, 0);
        checks++;
        if (obs_o !== 6'b111000) begin
            failures++;
            $display("FAIL md_start obs=%b exp=%b", obs_o, 6'b111000);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 0, 0);
            checks++;
            if (obs_o !== 6'b000001) begin
                failures++;
                $display("FAIL md_wait obs=%b exp=%b", obs_o, 6'b000001);
            end
        end
        step(1, 0, 0, 0, 1, 0);
        checks++;
        if (obs_o !== 6'b111000) begin
            failures++;
            $display("FAIL md_done obs=%b exp=%b", obs_o, 6'b111000);
        end
        checks++;
        if (int'(StallCount) != sc0 + 3) begin
            failures++;
            $display("FAIL md_stalls obs=%0d exp=%0d", StallCount, sc0 + 3);
        end
    endtask

    task automatic test_timeout();
        int sc0 = m_sc;
        step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < MDT - 1; i++) step(1, 0, 0, 0, 0, 0);
        checks++;
        if (MdTimeout !== 1'b0) begin
            failures++;
            $display("FAIL to_early obs=%b exp=0", MdTimeout);
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (MdTimeout !== 1'b1 || int'(StallCount) != sc0 + 63) begin
            failures++;
            $display("FAIL to_set obs=%b,%0d exp=1,%0d",
                     MdTimeout, StallCount, sc0 + 63);
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs_o !== 6'b111000) begin
            failures++;
            $display("FAIL to_run obs=%b exp=%b", obs_o, 6'b111000);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) != 0),
                 ($urandom_range(3) == 0), ($urandom_range(9) == 0),
                 ($urandom_range(11) == 0), ($urandom_range(4) == 0),
                 ($urandom_range(7) == 0));
            checks++;
            if (obs_o !== exp_o) begin
                failures++;
                $display("FAIL rnd_out cyc=%0d obs=%b exp=%b",
                         i, obs_o, exp_o);
            end
            checks++;
            if (int'(StallCount) != m_sc || int'(FlushCount) != m_fc
                || MdTimeout !== m_to) begin
                failures++;
                $display("FAIL rnd_cnt cyc=%0d obs=%0d/%0d/%b exp=%0d/%0d/%b",
                         i, StallCount, FlushCount, MdTimeout,
                         m_sc, m_fc, m_to);
            end
            checks++;
            if (int'(s_sc) != sat15(m_sc) || int'(s_fc) != sat15(m_fc)) begin
                failures++;
                $display("FAIL rnd_sat cyc=%0d obs=%0d/%0d exp=%0d/%0d",
                         i, s_sc, s_fc, sat15(m_sc), sat15(m_fc));
            end
        end
    endtask

    task automatic test_memwait();
        int sc0;
        while (m_sc < 16) begin
            step(1, 1, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        sc0 = m_sc;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 1, 0, 1);
            checks++;
            if (obs_o !== 6'b000000) begin
                failures++;
                $display("FAIL mw_freeze obs=%b exp=%b", obs_o, 6'b000000);
            end
        end
        checks++;
        if (int'(StallCount) != sc0 || s_sc !== 4'hF) begin
            failures++;
            $display("FAIL mw_hold obs=%0d,%0d exp=%0d,15",
                     StallCount, s_sc, sc0);
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs_o !== 6'b001010 || int'(StallCount) != sc0 + 1) begin
            failures++;
            $display("FAIL mw_resume obs=%b,%0d exp=%b,%0d",
                     obs_o, StallCount, 6'b001010, sc0 + 1);
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs_o !== 6'b111000 || s_sc !== 4'hF) begin
            failures++;
            $display("FAIL mw_end obs=%b,%0d exp=%b,15",
                     obs_o, s_sc, 6'b111000);
        end
    endtask

    initial begin
        Reset = 0; RawHazard = 0; BranchTaken = 0;
        MulDivStart = 0; MulDivDone = 0; MemWait = 0;
        test_reset();
        test_raw();
        test_raw_branch();
        test_muldiv();
        test_timeout();
        test_random();
        test_memwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
